// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream arbiter/multiplexer.
//   ARB_FIXED / ARB_RR : values of the Mode input
//   clog2()            : width helper used to size the grant index
package stream_arb_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Smallest r with 2**r >= value. The loop stops at 30 so the shift never
  // reaches the sign bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// Rotating-priority encoder. It searches upward from start_idx and wraps at
// NrOfInputs-1 -> 0. With start_idx = 0 it acts as a plain fixed-priority
// encoder, where index 0 has the highest priority.
//   req       in   request vector
//   start_idx in   index with the highest priority
//   grant_idx out  index of the winning request
//   grant_vld out  at least one request is set
module rr_grant_sel #(
  parameter int NrOfInputs = 4,
  parameter int SelBits    = 2
) (
  input  logic [NrOfInputs-1:0] req,
  input  logic [SelBits-1:0]    start_idx,
  output logic [SelBits-1:0]    grant_idx,
  output logic                  grant_vld
);

  always_comb begin
    int idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    // Walk from the farthest offset down to the nearest one. The last hit
    // written is the nearest one, so no early-exit flag is needed.
    for (int i = NrOfInputs - 1; i >= 0; i--) begin
      idx = (int'(start_idx) + i) % NrOfInputs;
      if (req[idx]) begin
        grant_idx = SelBits'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input valid/ready stream multiplexer with a built-in arbiter and one
// registered output stage. Sustained throughput is one beat per cycle.
// Optional feature: define STREAM_ARB_MUX_LOCK_EN to add packet lock. With
// it, a channel keeps the grant until it sends a beat with InLast set.
//   Clock, Reset_n   rising-edge clock, async active-low reset
//   Enable           low freezes the block and blanks OutValid/OutData
//   Mode             ARB_FIXED (channel 0 highest) or ARB_RR
//   InValid/InData   per-channel request and flattened data
//   InReady          one-hot (or zero) ready back to the granted channel
//   OutValid/OutData registered beat toward the consumer
//   OutSel           source channel of OutData
//   OutReady         consumer ready
//   InLast/OutLast   packet boundary (lock build only)
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int NrOfBits   = 32,
  parameter int NrOfInputs = 4,
  parameter int SelBits    = clog2(NrOfInputs)
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic                           Enable,
  input  logic                           Mode,
  input  logic [NrOfInputs-1:0]          InValid,
  input  logic [NrOfInputs*NrOfBits-1:0] InData,
  output logic [NrOfInputs-1:0]          InReady,
`ifdef STREAM_ARB_MUX_LOCK_EN
  input  logic [NrOfInputs-1:0]          InLast,
  output logic                           OutLast,
`endif
  output logic                           OutValid,
  output logic [NrOfBits-1:0]            OutData,
  output logic [SelBits-1:0]             OutSel,
  input  logic                           OutReady
);

  logic                  out_valid_q;
  logic [NrOfBits-1:0]   out_data_q;
  logic [SelBits-1:0]    out_sel_q;
  logic [SelBits-1:0]    ptr_q;
  logic [SelBits-1:0]    ptr_next;
  logic [SelBits-1:0]    start_idx;
  logic [SelBits-1:0]    grant_idx;
  logic [NrOfInputs-1:0] req;
  logic                  grant_vld;
  logic                  accept;
  logic                  xfer;
  logic                  advance;

`ifdef STREAM_ARB_MUX_LOCK_EN
  logic                  lock_q;
  logic [SelBits-1:0]    lock_idx_q;
  logic                  out_last_q;
`endif

  always_comb begin
    start_idx = (Mode == ARB_RR) ? ptr_q : '0;
    req       = InValid;
`ifdef STREAM_ARB_MUX_LOCK_EN
    // While a packet is open, only the locked channel may win. If it drops
    // valid, nobody is granted.
    if (lock_q) begin
      start_idx = lock_idx_q;
      req       = InValid & (NrOfInputs'(1) << lock_idx_q);
    end
`endif
  end

  rr_grant_sel #(
    .NrOfInputs (NrOfInputs),
    .SelBits    (SelBits)
  ) u_grant_sel (
    .req       (req),
    .start_idx (start_idx),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign accept  = Enable & (~out_valid_q | OutReady);
  assign xfer    = accept & grant_vld;
  assign InReady = xfer ? (NrOfInputs'(1) << grant_idx) : '0;

  assign ptr_next = (int'(grant_idx) + 1 == NrOfInputs) ? '0 : grant_idx + 1'b1;

`ifdef STREAM_ARB_MUX_LOCK_EN
  // The pointer moves only when a packet closes, so that the next packet
  // starts from the following channel.
  assign advance = xfer & (Mode == ARB_RR) & InLast[grant_idx];
`else
  assign advance = xfer & (Mode == ARB_RR);
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef STREAM_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= InData[int'(grant_idx)*NrOfBits +: NrOfBits];
        out_sel_q   <= grant_idx;
`ifdef STREAM_ARB_MUX_LOCK_EN
        lock_q      <= ~InLast[grant_idx];
        lock_idx_q  <= grant_idx;
        out_last_q  <= InLast[grant_idx];
`endif
      end else if (Enable && out_valid_q && OutReady) begin
        out_valid_q <= 1'b0;
      end
      if (advance) ptr_q <= ptr_next;
    end
  end

  // A disabled block blanks its output but keeps the beat. The beat shows
  // again when Enable returns.
  assign OutValid = Enable & out_valid_q;
  assign OutData  = Enable ? out_data_q : '0;
  assign OutSel   = out_sel_q;
`ifdef STREAM_ARB_MUX_LOCK_EN
  assign OutLast  = Enable & out_last_q;
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux (4 channels x 32 bits).
module tb_stream_arb_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SB = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           mode;
  logic           out_ready;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   ch_data [N];
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SB-1:0]  out_sel;
  logic           out_last;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the output register should hold.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign in_data[gi*W +: W] = ch_data[gi];
  end

  always #5 clk = ~clk;

  stream_arb_mux #(.NrOfBits(W), .NrOfInputs(N)) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .Enable   (en),
    .Mode     (mode),
    .InValid  (in_valid),
    .InData   (in_data),
    .InReady  (in_ready),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .InLast   (in_last),
    .OutLast  (out_last),
`endif
    .OutValid (out_valid),
    .OutData  (out_data),
    .OutSel   (out_sel),
    .OutReady (out_ready)
  );

`ifndef STREAM_ARB_MUX_LOCK_EN
  assign out_last = 1'b0;
`endif

  typedef struct {
    logic         en;
    logic         mode;
    logic [3:0]   vld;
    logic         rdy;
    logic [3:0]   exp_ready;
    logic         exp_ov;
    logic [W-1:0] exp_data;
    logic [1:0]   exp_sel;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode 0 picks the lowest valid index. Mode 1 scans upward from the
  // pointer and wraps around.
  function automatic void model_grant(input logic md, input logic [N-1:0] v, input int ptr,
                                      output int g, output bit gv);
    gv = 0;
    g  = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = md ? (ptr + k) % N : k;
      if (!gv && v[c]) begin
        g  = c;
        gv = 1;
      end
    end
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_check();
    int g;
    bit gv;
    bit acc;
    logic [N-1:0] er;
    model_grant(mode, in_valid, m_ptr, g, gv);
    acc = en && (!m_valid || out_ready);
    er  = (acc && gv) ? N'(1 << g) : '0;
    chk("rnd_in_ready", 32'(in_ready), 32'(er));
    chk("rnd_out_valid", 32'(out_valid), 32'(en && m_valid));
    chk("rnd_out_data", out_data, en ? m_data : '0);
    chk("rnd_out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  task automatic model_clock();
    int g;
    bit gv;
    bit acc;
    model_grant(mode, in_valid, m_ptr, g, gv);
    acc = en && (!m_valid || out_ready);
    if (acc && gv) begin
      m_valid = 1;
      m_data  = ch_data[g];
      m_sel   = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (en && m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_last   = '1;
    for (int c = 0; c < N; c++) ch_data[c] = W'(c * 32'h11);

    //              en mode vld   rdy  exp_rdy  ov  data    sel
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 32'h00, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 32'h00, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 32'h11, 2'd1};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 32'h22, 2'd2};
    tbl[4]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 32'h33, 2'd3};
    tbl[5]  = '{1'b1, 1'b0, 4'hA, 1'b1, 4'b0010, 1'b1, 32'h00, 2'd0};
    tbl[6]  = '{1'b1, 1'b0, 4'hA, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    tbl[7]  = '{1'b1, 1'b0, 4'hA, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    tbl[8]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'b0000, 1'b1, 32'h11, 2'd1};
    tbl[9]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'b0000, 1'b1, 32'h11, 2'd1};
    tbl[10] = '{1'b1, 1'b0, 4'hA, 1'b0, 4'b0000, 1'b1, 32'h11, 2'd1};
    tbl[11] = '{1'b1, 1'b0, 4'hA, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_sel", 32'(out_sel), 32'd0);

    // Round robin over four channels, then fixed priority with backpressure.
    for (int i = 0; i < 12; i++) begin
      en        = tbl[i].en;
      mode      = tbl[i].mode;
      in_valid  = tbl[i].vld;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
      model_clock();
      step();
    end

    // Reset in the middle of a held beat clears the output immediately.
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_out_data", out_data, 32'd0);
    chk("async_reset_out_sel", 32'(out_sel), 32'd0);
    step();
    rst_n = 1'b1;
    model_reset();
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    en        = 1'b1;
    #1;
    chk("post_reset_ptr0_grant", 32'(in_ready), 32'b0001);
    model_clock();
    step();

    // Drain. The pointer is now 1.
    in_valid = '0;
    #1;
    model_clock();
    step();

    // Load 0xDEADBEEF from channel 2. The pointer becomes 3.
    ch_data[2] = 32'hDEADBEEF;
    in_valid   = 4'b0100;
    out_ready  = 1'b0;
    #1;
    chk("en_load_in_ready", 32'(in_ready), 32'b0100);
    model_clock();
    step();

    en        = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("dis_out_valid", 32'(out_valid), 32'd0);
      chk("dis_out_data", out_data, 32'd0);
      chk("dis_in_ready", 32'(in_ready), 32'd0);
      model_clock();
      step();
    end

    en        = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("reen_out_valid", 32'(out_valid), 32'd1);
    chk("reen_out_data", out_data, 32'hDEADBEEF);
    chk("reen_out_sel", 32'(out_sel), 32'd2);
    chk("reen_in_ready", 32'(in_ready), 32'd0);
    model_clock();
    step();

    out_ready = 1'b1;
    #1;
    chk("reen_ptr_kept", 32'(in_ready), 32'b1000);
    model_clock();
    step();

    // Randomized traffic checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      mode      = 1'($urandom_range(0, 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) ch_data[c] = $urandom;
      #1;
      model_check();
      model_clock();
      step();
    end

`ifdef STREAM_ARB_MUX_LOCK_EN
    // Channel 2 sends a 3-beat packet while channel 3 also has data.
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    en         = 1'b1;
    mode       = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 4'b1100;
    in_last    = 4'b0000;
    ch_data[2] = 32'hC0DE0002;
    ch_data[3] = 32'hC0DE0003;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("lock_beat%0d_in_ready", b), 32'(in_ready), 32'b0100);
      step();
    end
    in_last = 4'b1111;
    #1;
    chk("lock_release_in_ready", 32'(in_ready), 32'b1000);
    chk("lock_out_last", 32'(out_last), 32'd1);
    chk("lock_out_sel", 32'(out_sel), 32'd2);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
